sramlike_arbiter: RTL

//  Shares one sram-like slave port (AXI bridge side) between the instruction-fetch master (m0) and
//  the data load/store master (m1). Grants one address phase per cycle, holds the grant until

---
 rtl/sramlike_pkg.sv | 13 +
 rtl/sramlike_owner_fifo.sv | 52 +++++
 rtl/sramlike_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sramlike_pkg.sv
// Shared types and widths for the sram-like arbiter slice.
package sramlike_pkg;

  localparam int SRAMLIKE_ADDR_W = 32;
  localparam int SRAMLIKE_DATA_W = 32;
  localparam int SRAMLIKE_BEN_W  = 4;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_t;

endpackage

// File: rtl/sramlike_owner_fifo.sv
// Owner-ID FIFO: remembers which master issued each accepted request so
// in-order responses can be routed back. DEPTH must be a power of 2, >= 2.
module sramlike_owner_fifo
  import sramlike_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  owner_t push_id,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output owner_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  owner_t             slots [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = slots[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/sramlike_arbiter.sv
// Two-master sram-like arbiter (inst m0, data m1) onto one slave port.
// Define SRAMLIKE_ARB_RR_EN for round-robin; default is fixed priority m1 > m0.
module sramlike_arbiter
  import sramlike_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                       clk,
  input  logic                       reset,

  input  logic                       m0_req,
  input  logic                       m0_wr,
  input  logic [SRAMLIKE_BEN_W-1:0]  m0_ben,
  input  logic [SRAMLIKE_ADDR_W-1:0] m0_addr,
  input  logic [SRAMLIKE_DATA_W-1:0] m0_wdata,
  output logic                       m0_addr_ok,
  output logic                       m0_data_ok,
  output logic [SRAMLIKE_DATA_W-1:0] m0_rdata,

  input  logic                       m1_req,
  input  logic                       m1_wr,
  input  logic [SRAMLIKE_BEN_W-1:0]  m1_ben,
  input  logic [SRAMLIKE_ADDR_W-1:0] m1_addr,
  input  logic [SRAMLIKE_DATA_W-1:0] m1_wdata,
  output logic                       m1_addr_ok,
  output logic                       m1_data_ok,
  output logic [SRAMLIKE_DATA_W-1:0] m1_rdata,

  output logic                       s_req,
  output logic                       s_wr,
  output logic [SRAMLIKE_BEN_W-1:0]  s_ben,
  output logic [SRAMLIKE_ADDR_W-1:0] s_addr,
  output logic [SRAMLIKE_DATA_W-1:0] s_wdata,
  input  logic                       s_addr_ok,
  input  logic                       s_data_ok,
  input  logic [SRAMLIKE_DATA_W-1:0] s_rdata
);

  owner_t grant;
  owner_t lock_owner;
  owner_t head;
  logic   lock;
  logic   grant_req;
  logic   accept;
  logic   fifo_full;
  logic   fifo_empty;

`ifdef SRAMLIKE_ARB_RR_EN
  owner_t rr_ptr;
`endif

  // A locked owner keeps the slave port until addr_ok; otherwise arbitrate.
  always_comb begin
    grant = OWNER_INST;
    if (lock) begin
      grant = lock_owner;
    end else if (m0_req && m1_req) begin
`ifdef SRAMLIKE_ARB_RR_EN
      grant = rr_ptr;
`else
      grant = OWNER_DATA;
`endif
    end else if (m1_req) begin
      grant = OWNER_DATA;
    end
    grant_req = (grant == OWNER_DATA) ? m1_req : m0_req;
  end

  assign s_req  = grant_req && !fifo_full && !reset;
  assign accept = s_req && s_addr_ok;

  always_comb begin
    s_wr    = 1'b0;
    s_ben   = '0;
    s_addr  = '0;
    s_wdata = '0;
    if (s_req) begin
      if (grant == OWNER_DATA) begin
        s_wr    = m1_wr;
        s_ben   = m1_ben;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
      end else begin
        s_wr    = m0_wr;
        s_ben   = m0_ben;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
      end
    end
  end

  assign m0_addr_ok = accept && (grant == OWNER_INST);
  assign m1_addr_ok = accept && (grant == OWNER_DATA);

  // Lock clears on acceptance or if the owner abandons its request.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock       <= 1'b0;
      lock_owner <= OWNER_INST;
    end else if (accept) begin
      lock <= 1'b0;
    end else if (s_req) begin
      lock       <= 1'b1;
      lock_owner <= grant;
    end else if (lock && !grant_req) begin
      lock <= 1'b0;
    end
  end

`ifdef SRAMLIKE_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset)       rr_ptr <= OWNER_INST;
    else if (accept) rr_ptr <= owner_t'(~grant);
  end
`endif

  sramlike_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (accept),
    .push_id (grant),
    .pop     (s_data_ok && !reset),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head)
  );

  assign m0_data_ok = s_data_ok && !fifo_empty && (head == OWNER_INST) && !reset;
  assign m1_data_ok = s_data_ok && !fifo_empty && (head == OWNER_DATA) && !reset;
  assign m0_rdata   = reset ? '0 : s_rdata;
  assign m1_rdata   = reset ? '0 : s_rdata;

  a_no_stray_data_ok: assert property (@(posedge clk) disable iff (reset)
    !(s_data_ok && fifo_empty));

endmodule
